stdout_uart_tx: RTL and testbench

- Downstream consumer of the processor's stdout/stdout_en output.
- Buffers output bytes in a small FIFO and serialises them on a single UART line, 8N1, LSB first.
- Provides a full flag the top level uses to drop the processor's en, which back-pressures program execution.
- Sticky overflow flag records any byte lost while the FIFO was full.

---
 rtl/stdout_uart_tx.sv | 216 +++++++++++++++++++++
 tb/tb_stdout_uart_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stdout_uart_tx.sv
// ---------------------------------------------------------------------------
// stdout_uart_tx
//
// Takes the processor's stdout byte stream and sends it out on a UART line.
// Bytes are buffered in a small FIFO and transmitted 8N1, LSB first. The
// buffered bytes are serialised back to back, with no idle gap between frames.
//
// Ports:
//   clk        - clock, all logic on posedge
//   reset      - asynchronous, active-high reset
//   stdout     - byte from the processor, valid while stdout_en is high
//   stdout_en  - byte strobe; only its rising edge pushes a byte
//   tx         - UART serial output, idles high, driven from a flop
//   full       - FIFO holds 2**FIFO_ADDR_WIDTH bytes; top level gates the
//                processor enable with this to apply back-pressure
//   busy       - FIFO non-empty or a frame in progress
//   overflow   - sticky: a byte was dropped because the FIFO was full
//   fifo_count - current FIFO occupancy
//   state_dbg  - current transmit FSM state (IDLE=0, START=1, DATA=2, STOP=3)
//
// Handshake: there is no ready signal. The producer presents a byte with a
// rising edge on stdout_en and must watch 'full'. A rising edge that arrives
// while the FIFO is full, with no pop in the same cycle, loses its byte and
// sets 'overflow'.
// ---------------------------------------------------------------------------
module stdout_uart_tx #(
  parameter int CLK_DIV         = 104,
  parameter int FIFO_ADDR_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               stdout,
  input  logic                     stdout_en,
  output logic                     tx,
  output logic                     full,
  output logic                     busy,
  output logic                     overflow,
  output logic [FIFO_ADDR_WIDTH:0] fifo_count,
  output logic [1:0]               state_dbg
);

  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0]           BIT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]           BIT_ONE  = CNT_W'(1);
  localparam logic [FIFO_ADDR_WIDTH:0]   CNT_FULL = (FIFO_ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [FIFO_ADDR_WIDTH:0]   CNT_ONE  = (FIFO_ADDR_WIDTH + 1)'(1);
  localparam logic [FIFO_ADDR_WIDTH-1:0] PTR_ONE  = FIFO_ADDR_WIDTH'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Storage
  logic [7:0]                 mem_q [DEPTH];

  // Flops
  logic                       en_q;
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q,   wr_ptr_d;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q,   rd_ptr_d;
  logic [FIFO_ADDR_WIDTH:0]   count_q,    count_d;
  logic                       overflow_q, overflow_d;
  logic [1:0]                 state_q,    state_d;
  logic [CNT_W-1:0]           bit_cnt_q,  bit_cnt_d;
  logic [2:0]                 bit_idx_q,  bit_idx_d;
  logic [7:0]                 shift_q,    shift_d;
  logic                       tx_q,       tx_d;

  // Combinational helpers
  logic       push;
  logic       push_ok;
  logic       pop;
  logic       fifo_empty;
  logic       fifo_full;
  logic       bit_last;
  logic [7:0] head;

  // ---------------------------------------------------------------------------
  // Transmit FSM. tx_d is the line level for the *next* cycle, so tx_q changes
  // on the same edge as the state does and the line never glitches.
  // ---------------------------------------------------------------------------
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_FULL);
    bit_last   = (bit_cnt_q == BIT_LAST);
    head       = mem_q[rd_ptr_q];

    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = head;
          bit_cnt_d = '0;
          tx_d      = 1'b0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
          state_d   = S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_ONE;
        end
      end
      S_DATA: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            // Bit 1 of the current shift value is the next bit to go out.
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_ONE;
        end
      end
      S_STOP: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          if (!fifo_empty) begin
            // Back-to-back: the next start bit follows the stop bit directly.
            pop     = 1'b1;
            shift_d = head;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_ONE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping. A pop reads the head combinationally before the edge, so
  // a push into the same slot on a full FIFO (wr_ptr == rd_ptr) is safe.
  // ---------------------------------------------------------------------------
  always_comb begin
    push       = stdout_en & ~en_q;
    push_ok    = push & (~fifo_full | pop);
    overflow_d = overflow_q | (push & fifo_full & ~pop);

    wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop     ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= stdout;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      en_q       <= stdout_en;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  assign tx         = tx_q;
  assign full       = (count_q == CNT_FULL);
  assign busy       = (state_q != S_IDLE) | (count_q != '0);
  assign overflow   = overflow_q;
  assign fifo_count = count_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_stdout_uart_tx.sv
// ---------------------------------------------------------------------------
// Directed testbench for stdout_uart_tx.
// dut0: CLK_DIV=4,  depth 16 (main traffic, wrap-around, reset mid-frame)
// dut1: CLK_DIV=16, depth 4  (overflow)
// A line monitor decodes every frame on each tx line and compares the decoded
// bytes against the expected queues. The directed steps push hand-computed
// bytes into those queues.
// ---------------------------------------------------------------------------
module tb_stdout_uart_tx;

  logic       clk;
  logic       reset;
  logic [7:0] d0, d1;
  logic       en0, en1;
  logic       tx0, full0, busy0, ovf0;
  logic       tx1, full1, busy1, ovf1;
  logic [4:0] cnt0;
  logic [2:0] cnt1;
  logic [1:0] st0, st1;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp0_q[$];
  logic [7:0] exp1_q[$];
  int         st0_q[$];

  int         frames0 = 0;
  int         frames1 = 0;
  int         peak0 = 0;
  int         cyc_now = 0;
  int         f_base;

  // line monitor state, index 0 -> dut0, 1 -> dut1
  logic       m_act [2];
  int         m_cyc [2];
  logic [7:0] m_bits[2];
  logic       m_fe  [2];
  logic       mon_tx;
  int         mon_div;
  int         mon_j;

  stdout_uart_tx #(.CLK_DIV(4), .FIFO_ADDR_WIDTH(4)) u_dut0 (
    .clk(clk), .reset(reset), .stdout(d0), .stdout_en(en0),
    .tx(tx0), .full(full0), .busy(busy0), .overflow(ovf0),
    .fifo_count(cnt0), .state_dbg(st0)
  );

  stdout_uart_tx #(.CLK_DIV(16), .FIFO_ADDR_WIDTH(2)) u_dut1 (
    .clk(clk), .reset(reset), .stdout(d1), .stdout_en(en1),
    .tx(tx1), .full(full1), .busy(busy1), .overflow(ovf1),
    .fifo_count(cnt1), .state_dbg(st1)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic frame_done(input int k, input logic [7:0] b, input logic fe);
    if (k == 0) begin
      frames0++;
      check("rx0_framing", {31'd0, fe}, 0);
      check("rx0_pending", {31'd0, exp0_q.size() != 0}, 1);
      if (exp0_q.size() != 0) check("rx0_byte", {24'd0, b}, {24'd0, exp0_q.pop_front()});
    end else begin
      frames1++;
      check("rx1_framing", {31'd0, fe}, 0);
      check("rx1_pending", {31'd0, exp1_q.size() != 0}, 1);
      if (exp1_q.size() != 0) check("rx1_byte", {24'd0, b}, {24'd0, exp1_q.pop_front()});
    end
  endtask

  // Line monitor: samples each bit in the middle of its period on negedges.
  always @(negedge clk) begin
    cyc_now++;
    if (int'(cnt0) > peak0) peak0 = int'(cnt0);
    for (int k = 0; k < 2; k++) begin
      mon_tx  = (k == 0) ? tx0 : tx1;
      mon_div = (k == 0) ? 4 : 16;
      if (reset) begin
        m_act[k] = 1'b0;
      end else if (!m_act[k]) begin
        if (!mon_tx) begin
          m_act[k] = 1'b1;
          m_cyc[k] = 0;
          m_fe[k]  = 1'b0;
          if (k == 0) st0_q.push_back(cyc_now);
        end
      end else begin
        m_cyc[k]++;
        if ((m_cyc[k] % mon_div) == (mon_div / 2)) begin
          mon_j = m_cyc[k] / mon_div;
          if (mon_j == 0)      m_fe[k] = m_fe[k] | mon_tx;
          else if (mon_j == 9) m_fe[k] = m_fe[k] | ~mon_tx;
          else                 m_bits[k][mon_j-1] = mon_tx;
        end
        if (m_cyc[k] == 10 * mon_div - 1) begin
          m_act[k] = 1'b0;
          frame_done(k, m_bits[k], m_fe[k]);
        end
      end
    end
  end

  // One-cycle strobe: en high for exactly one rising edge.
  task automatic strobe(input int k, input logic [7:0] b);
    @(negedge clk);
    if (k == 0) begin d0 = b; en0 = 1'b1; end
    else        begin d1 = b; en1 = 1'b1; end
    @(negedge clk);
    if (k == 0) en0 = 1'b0;
    else        en1 = 1'b0;
  endtask

  task automatic wait_idle(input int k, input int budget);
    int n;
    n = 0;
    while (((k == 0) ? busy0 : busy1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, (k == 0) ? busy0 : busy1}, 0);
  endtask

  initial begin
    reset = 1'b1;
    en0 = 1'b0; en1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 1'b0; m_cyc[k] = 0; m_bits[k] = 8'h00; m_fe[k] = 1'b0;
    end

    // ---- reset state ----
    #1;
    check("rst_tx0",    {31'd0, tx0},   1);
    check("rst_full0",  {31'd0, full0}, 0);
    check("rst_busy0",  {31'd0, busy0}, 0);
    check("rst_ovf0",   {31'd0, ovf0},  0);
    check("rst_cnt0",   {27'd0, cnt0},  0);
    check("rst_state0", {30'd0, st0},   0);
    check("rst_tx1",    {31'd0, tx1},   1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // ---- single byte 0x48 ----
    exp0_q.push_back(8'h48);
    f_base = frames0;
    strobe(0, 8'h48);
    check("t1_cnt_after_push", {27'd0, cnt0}, 1);
    check("t1_busy_after_push", {31'd0, busy0}, 1);
    check("t1_tx_before_start", {31'd0, tx0}, 1);
    @(negedge clk);
    check("t1_tx_start", {31'd0, tx0}, 0);
    check("t1_cnt_popped", {27'd0, cnt0}, 0);
    check("t1_state_start", {30'd0, st0}, 1);
    repeat (17) @(negedge clk);
    check("t1_tx_bit3", {31'd0, tx0}, 1);
    repeat (22) @(negedge clk);
    check("t1_tx_stop", {31'd0, tx0}, 1);
    check("t1_busy_in_stop", {31'd0, busy0}, 1);
    @(negedge clk);
    check("t1_busy_dropped", {31'd0, busy0}, 0);
    check("t1_frames", frames0 - f_base, 1);
    check("t1_exp_drained", exp0_q.size(), 0);

    // ---- held strobe, 50 cycles of 0x55 ----
    repeat (3) @(negedge clk);
    f_base = frames0;
    peak0  = 0;
    exp0_q.push_back(8'h55);
    d0 = 8'h55; en0 = 1'b1;
    repeat (50) @(negedge clk);
    en0 = 1'b0;
    wait_idle(0, 200);
    repeat (5) @(negedge clk);
    check("t2_frames", frames0 - f_base, 1);
    check("t2_peak", peak0, 1);
    check("t2_ovf", {31'd0, ovf0}, 0);

    // ---- back-to-back 0x41,0x42,0x43 ----
    f_base = frames0;
    peak0  = 0;
    st0_q.delete();
    exp0_q.push_back(8'h41); exp0_q.push_back(8'h42); exp0_q.push_back(8'h43);
    strobe(0, 8'h41);
    strobe(0, 8'h42);
    strobe(0, 8'h43);
    wait_idle(0, 300);
    check("t3_frames", frames0 - f_base, 3);
    check("t3_peak", peak0, 2);
    check("t3_starts", st0_q.size(), 3);
    if (st0_q.size() == 3) begin
      check("t3_gap01", st0_q[1] - st0_q[0], 40);
      check("t3_gap12", st0_q[2] - st0_q[1], 40);
    end
    check("t3_exp_drained", exp0_q.size(), 0);

    // ---- overflow on dut1 (depth 4, CLK_DIV 16) ----
    for (int i = 1; i <= 5; i++) exp1_q.push_back(8'(i));
    for (int i = 1; i <= 5; i++) strobe(1, 8'(i));
    check("t4_full_after5", {31'd0, full1}, 1);
    check("t4_cnt_after5", {29'd0, cnt1}, 4);
    check("t4_ovf_before6", {31'd0, ovf1}, 0);
    strobe(1, 8'd6);
    check("t4_ovf_after6", {31'd0, ovf1}, 1);
    check("t4_cnt_after6", {29'd0, cnt1}, 4);
    wait_idle(1, 1200);
    check("t4_ovf_sticky", {31'd0, ovf1}, 1);
    check("t4_full_drained", {31'd0, full1}, 0);
    check("t4_frames", frames1, 5);
    check("t4_exp_drained", exp1_q.size(), 0);

    // ---- wrap-around: 40 bytes in bursts of 10 ----
    f_base = frames0;
    for (int b = 0; b < 4; b++) begin
      peak0 = 0;
      for (int i = 0; i < 10; i++) begin
        exp0_q.push_back(8'(b * 10 + i));
        strobe(0, 8'(b * 10 + i));
      end
      wait_idle(0, 700);
      check("t5_burst_peak", peak0, 9);
    end
    check("t5_frames", frames0 - f_base, 40);
    check("t5_cnt", {27'd0, cnt0}, 0);
    check("t5_ovf", {31'd0, ovf0}, 0);
    check("t5_exp_drained", exp0_q.size(), 0);

    // ---- reset mid-frame during DATA bit 3 of 0xA5 ----
    exp0_q.push_back(8'hA5);
    strobe(0, 8'hA5);
    strobe(0, 8'h11);
    strobe(0, 8'h22);
    repeat (14) @(negedge clk);
    check("t6_cnt_queued", {27'd0, cnt0}, 2);
    check("t6_tx_bit3", {31'd0, tx0}, 0);
    check("t6_state_data", {30'd0, st0}, 2);
    #1 reset = 1'b1;
    exp0_q.delete();
    #1;
    check("t6_tx_async", {31'd0, tx0}, 1);
    check("t6_cnt_async", {27'd0, cnt0}, 0);
    check("t6_busy_async", {31'd0, busy0}, 0);
    check("t6_ovf1_cleared", {31'd0, ovf1}, 0);
    // strobe while reset is held must not push anything
    @(negedge clk);
    d0 = 8'hEE; en0 = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_strobe_in_reset", {27'd0, cnt0}, 0);
    en0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_cnt_after_release", {27'd0, cnt0}, 0);
    f_base = frames0;
    exp0_q.push_back(8'h0F);
    strobe(0, 8'h0F);
    wait_idle(0, 200);
    check("t6_frames", frames0 - f_base, 1);
    check("t6_exp_drained", exp0_q.size(), 0);
    check("t6_tx_idle", {31'd0, tx0}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
